intra4x4_pred_mode_ctrl: RTL and testbench



---
 rtl/intra4x4_pred_mode_ctrl.sv | 121 ++++++++++++
 tb/tb_intra4x4_pred_mode_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra4x4_pred_mode_ctrl.sv
// intra4x4_pred_mode_ctrl: sequences the 16 Intra4x4 mode decodes of a MB
// and keeps the up-row line buffer and left-MB neighbour context.
module intra4x4_pred_mode_ctrl #(
  parameter int MB_X_BITS = 4,
  parameter int MB_Y_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           mb_is_i4,
  input  logic [MB_X_BITS-1:0]           mb_x_in,
  input  logic [MB_Y_BITS-1:0]           mb_y_in,
  input  logic [MB_X_BITS+MB_Y_BITS-1:0] slice_mb_index_in,
  input  logic                           pm_valid,
  output logic                           pm_ready,
  input  logic                           prev_flag,
  input  logic [2:0]                     rem_mode,
  output logic [MB_X_BITS-1:0]           mb_x,
  output logic [MB_Y_BITS-1:0]           mb_y,
  output logic [MB_X_BITS+MB_Y_BITS-1:0] slice_mb_index,
  output logic [3:0]                     luma4x4BlkIdx,
  output logic                           prev_out,
  output logic [2:0]                     rem_out,
  output logic [15:0]                    up_mb_modes,
  output logic [15:0]                    left_mb_modes,
  output logic [63:0]                    curr_mb_modes,
  input  logic [3:0]                     dec_mode,
  output logic                           mode_valid,
  output logic [3:0]                     mode_out,
  output logic [3:0]                     mode_blk,
  output logic                           busy,
  output logic                           done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB,
    DONE
  } state_t;

  localparam int LB_DEPTH = 2 ** MB_X_BITS;

  state_t      state;
  logic [3:0]  blk_cnt;
  logic [15:0] line_buf [LB_DEPTH];
  logic        hs;

  assign pm_ready      = (state == RUN);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign hs            = pm_valid & pm_ready;
  assign luma4x4BlkIdx = blk_cnt;
  assign prev_out      = prev_flag;
  assign rem_out       = rem_mode;

  // MB sequencing: latch position, collect 16 modes, save neighbour context.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      blk_cnt        <= '0;
      mb_x           <= '0;
      mb_y           <= '0;
      slice_mb_index <= '0;
      up_mb_modes    <= '0;
      left_mb_modes  <= '0;
      curr_mb_modes  <= '0;
      mode_valid     <= 1'b0;
      mode_out       <= '0;
      mode_blk       <= '0;
    end else begin
      mode_valid <= hs;
      unique case (state)
        IDLE: begin
          if (start) begin
            mb_x           <= mb_x_in;
            mb_y           <= mb_y_in;
            slice_mb_index <= slice_mb_index_in;
            up_mb_modes    <= line_buf[mb_x_in];
            blk_cnt        <= '0;
            if (mb_is_i4) begin
              state <= RUN;
            end else begin
              curr_mb_modes <= 64'h2222_2222_2222_2222;
              state         <= WB;
            end
          end
        end
        RUN: begin
          if (hs) begin
            curr_mb_modes[{blk_cnt, 2'b00} +: 4] <= dec_mode;
            mode_out <= dec_mode;
            mode_blk <= blk_cnt;
            blk_cnt  <= blk_cnt + 4'd1;
            if (blk_cnt == 4'd15) state <= WB;
          end
        end
        WB: begin
          left_mb_modes <= {curr_mb_modes[63:60],
                            curr_mb_modes[55:52],
                            curr_mb_modes[31:28],
                            curr_mb_modes[23:20]};
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Up-row line buffer holds the bottom row of each MB column; never reset.
  always_ff @(posedge clk) begin
    if (rst_n && state == WB) begin
      line_buf[mb_x] <= {curr_mb_modes[63:60],
                         curr_mb_modes[59:56],
                         curr_mb_modes[47:44],
                         curr_mb_modes[43:40]};
    end
  end

endmodule

// File: tb/tb_intra4x4_pred_mode_ctrl.sv
// tb_intra4x4_pred_mode_ctrl: directed bench with a decoder stub and
// a MB-level reference model of the controller's neighbour context.
module tb_intra4x4_pred_mode_ctrl;

  localparam int XB = 2;
  localparam int YB = 2;
  localparam int W  = 2 ** XB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mb_is_i4;
  logic [XB-1:0] mb_x_in;
  logic [YB-1:0] mb_y_in;
  logic [XB+YB-1:0] slice_mb_index_in;
  logic          pm_valid;
  logic          pm_ready;
  logic          prev_flag;
  logic [2:0]    rem_mode;
  logic [XB-1:0] mb_x;
  logic [YB-1:0] mb_y;
  logic [XB+YB-1:0] slice_mb_index;
  logic [3:0]    luma4x4BlkIdx;
  logic          prev_out;
  logic [2:0]    rem_out;
  logic [15:0]   up_mb_modes;
  logic [15:0]   left_mb_modes;
  logic [63:0]   curr_mb_modes;
  logic [3:0]    dec_mode;
  logic          mode_valid;
  logic [3:0]    mode_out;
  logic [3:0]    mode_blk;
  logic          busy;
  logic          done;

  intra4x4_pred_mode_ctrl #(
    .MB_X_BITS(XB),
    .MB_Y_BITS(YB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mb_is_i4(mb_is_i4),
    .mb_x_in(mb_x_in),
    .mb_y_in(mb_y_in),
    .slice_mb_index_in(slice_mb_index_in),
    .pm_valid(pm_valid),
    .pm_ready(pm_ready),
    .prev_flag(prev_flag),
    .rem_mode(rem_mode),
    .mb_x(mb_x),
    .mb_y(mb_y),
    .slice_mb_index(slice_mb_index),
    .luma4x4BlkIdx(luma4x4BlkIdx),
    .prev_out(prev_out),
    .rem_out(rem_out),
    .up_mb_modes(up_mb_modes),
    .left_mb_modes(left_mb_modes),
    .curr_mb_modes(curr_mb_modes),
    .dec_mode(dec_mode),
    .mode_valid(mode_valid),
    .mode_out(mode_out),
    .mode_blk(mode_blk),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_strobe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // H.264 Intra4x4PredMode derivation for one block (decoder stub).
  function automatic int bidx(int x, int y);
    return (y / 2) * 8 + (x / 2) * 4 + (y % 2) * 2 + (x % 2);
  endfunction

  function automatic logic [3:0] dec_fn(
    int k, logic pf, logic [2:0] rm, logic [63:0] cur,
    logic [15:0] up, logic [15:0] lf,
    int mbx, int mby, int sidx);
    int x, y, lm, um, mpm, r;
    bit la, ua;
    x  = ((k / 4) % 2) * 2 + (k % 2);
    y  = ((k / 8) % 2) * 2 + ((k / 2) % 2);
    la = (x > 0) || (mbx > 0 && sidx > 0);
    ua = (y > 0) || (mby > 0 && sidx >= W);
    lm = (x > 0) ? int'(cur[4 * bidx(x - 1, y) +: 4])
                 : int'(lf[4 * y +: 4]);
    um = (y > 0) ? int'(cur[4 * bidx(x, y - 1) +: 4])
                 : int'(up[4 * x +: 4]);
    mpm = (la && ua) ? ((lm < um) ? lm : um) : 2;
    r = int'(rm);
    if (pf) return 4'(mpm);
    return (r < mpm) ? 4'(r) : 4'(r + 1);
  endfunction

  always_comb begin
    dec_mode = dec_fn(int'(luma4x4BlkIdx), prev_out, rem_out,
                      curr_mb_modes, up_mb_modes, left_mb_modes,
                      int'(mb_x), int'(mb_y), int'(slice_mb_index));
  end

  // Reference model state
  logic [15:0] m_line [W];
  bit          m_ok   [W];
  logic [15:0] m_left;
  logic [63:0] exp_cur;
  logic [15:0] exp_left;
  logic [15:0] exp_line;
  logic [7:0]  exp_q [$];
  logic [3:0]  got    [16];
  logic [3:0]  saved  [16];
  bit          pf_a   [16];
  logic [2:0]  rm_a   [16];
  logic [15:0] up_c1;
  logic [15:0] left_c1;

  task automatic model_mb(int mbx, int mby, int sidx,
                          bit i4, int nblk);
    logic [63:0] cur;
    logic [3:0]  m;
    cur = '0;
    for (int k = 0; k < 16; k++) begin
      if (i4)
        m = dec_fn(k, pf_a[k], rm_a[k], cur, m_line[mbx],
                   m_left, mbx, mby, sidx);
      else
        m = 4'd2;
      cur[4 * k +: 4] = m;
      if (i4 && k < nblk) exp_q.push_back({4'(k), m});
    end
    exp_cur  = cur;
    exp_line = {cur[63:60], cur[59:56], cur[47:44], cur[43:40]};
    exp_left = {cur[63:60], cur[55:52], cur[31:28], cur[23:20]};
  endtask

  // Every decoded-mode strobe must match the model's next entry.
  always @(negedge clk) begin
    logic [7:0] e;
    if (cyc >= 2 && mode_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {mode_blk, mode_out}, 8'h0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe", {mode_blk, mode_out}, e);
        got[mode_blk] = mode_out;
        n_strobe++;
      end
    end
  end

  task automatic run_mb(int mbx, int mby, int sidx, bit i4,
                        bit gaps, bit poke, int nblk);
    int  c0, k, idle, p, w;
    bit  v, up_ok;
    logic [15:0] up_want;
    up_ok   = m_ok[mbx];
    up_want = m_line[mbx];
    model_mb(mbx, mby, sidx, i4, nblk);
    n_strobe = 0;
    @(negedge clk);
    start = 1'b1;
    mb_is_i4 = i4;
    mb_x_in = XB'(mbx);
    mb_y_in = YB'(mby);
    slice_mb_index_in = (XB + YB)'(sidx);
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    up_c1 = up_mb_modes;
    left_c1 = left_mb_modes;
    chk("busy_c1", busy, 1);
    chk("ready_c1", pm_ready, i4);
    chk("mb_x", mb_x, mbx);
    chk("mb_y", mb_y, mby);
    chk("sidx", slice_mb_index, sidx);
    if (up_ok) chk("up_modes", up_mb_modes, up_want);
    idle = 0;
    if (i4) begin
      if (poke) begin
        start = 1'b1;
        mb_x_in = XB'(mbx + 1);
      end
      k = 0; p = 0; w = 0;
      while (k < nblk && w < 200) begin
        v = gaps ? (p % 3 == 0) : 1'b1;
        p++;
        pm_valid = v;
        prev_flag = pf_a[k];
        rem_mode = rm_a[k];
        #1;
        chk("ready_run", pm_ready, 1);
        chk("blk_idx", luma4x4BlkIdx, k);
        chk("pass", {prev_out, rem_out}, {pf_a[k], rm_a[k]});
        @(negedge clk);
        w++;
        if (v) k++;
        else idle++;
      end
      pm_valid = 1'b0;
      if (w >= 200) chk("run_timeout", w, 0);
      if (nblk < 16) begin
        start = 1'b0;
        return;
      end
    end
    w = 0;
    while (done !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("done_lat", cyc - c0, i4 ? 18 + idle : 2);
    chk("n_strobes", n_strobe, i4 ? 16 : 0);
    chk("left_modes", left_mb_modes, exp_left);
    chk("curr_modes", curr_mb_modes, exp_cur);
    if (poke) chk("mb_x_hold", mb_x, mbx);
    m_line[mbx] = exp_line;
    m_ok[mbx] = 1'b1;
    m_left = exp_left;
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
  endtask

  task automatic set_pat(int kind);
    for (int k = 0; k < 16; k++) begin
      unique case (kind)
        0: begin pf_a[k] = 1'b0; rm_a[k] = 3'd7; end
        1: begin pf_a[k] = 1'b1; rm_a[k] = 3'd0; end
        default: begin
          pf_a[k] = (k % 3 == 0);
          rm_a[k] = 3'((k * 5 + 1) % 8);
        end
      endcase
    end
  endtask

  initial begin
    logic [3:0] idx0;
    rst_n = 1'b0; start = 1'b0; mb_is_i4 = 1'b0;
    mb_x_in = '0; mb_y_in = '0; slice_mb_index_in = '0;
    pm_valid = 1'b0; prev_flag = 1'b0; rem_mode = '0;
    m_left = '0;
    for (int i = 0; i < W; i++) begin
      m_ok[i] = 1'b0;
      m_line[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", pm_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mv", mode_valid, 0);
    chk("rst_mout", mode_out, 0);
    chk("rst_mblk", mode_blk, 0);
    chk("rst_idx", luma4x4BlkIdx, 0);
    chk("rst_curr", curr_mb_modes, 0);
    chk("rst_left", left_mb_modes, 0);
    chk("rst_up", up_mb_modes, 0);
    chk("rst_pos", {mb_x, mb_y, slice_mb_index}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_pat(0);
    run_mb(0, 0, 0, 1'b1, 1'b0, 1'b0, 16);
    chk("lit_blk0", got[0], 8);
    chk("lit_blk1", got[1], 8);
    chk("lit_blk3", got[3], 7);
    for (int k = 0; k < 16; k++) saved[k] = got[k];

    set_pat(1);
    run_mb(0, 0, 0, 1'b1, 1'b0, 1'b0, 16);
    for (int k = 0; k < 16; k++) chk("lit_all2", got[k], 2);
    chk("lit_left2222", left_mb_modes, 16'h2222);

    run_mb(0, 0, 0, 1'b0, 1'b0, 1'b0, 16);
    chk("lit_line0", up_c1, 16'h2222);
    run_mb(1, 0, 1, 1'b1, 1'b0, 1'b0, 16);
    chk("lit_left_c1", left_c1, 16'h2222);
    chk("lit_blk4", got[4], 2);

    set_pat(2);
    run_mb(2, 0, 2, 1'b1, 1'b0, 1'b0, 16);
    run_mb(3, 0, 3, 1'b1, 1'b0, 1'b1, 16);

    set_pat(0);
    run_mb(0, 0, 0, 1'b1, 1'b1, 1'b0, 16);
    for (int k = 0; k < 16; k++) chk("bp_same", got[k], saved[k]);

    idx0 = luma4x4BlkIdx;
    pm_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_ready", pm_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_mv", mode_valid, 0);
      chk("idle_idx", luma4x4BlkIdx, idx0);
    end
    pm_valid = 1'b0;

    set_pat(2);
    run_mb(1, 0, 1, 1'b1, 1'b0, 1'b0, 7);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_busy", busy, 0);
    chk("mr_mv", mode_valid, 0);
    chk("mr_curr", curr_mb_modes, 0);
    chk("mr_left", left_mb_modes, 0);
    chk("mr_ready", pm_ready, 0);
    chk("mr_strobes", n_strobe, 7);
    exp_q.delete();
    m_left = '0;
    run_mb(2, 0, 2, 1'b1, 1'b0, 1'b0, 16);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d want 0", cyc);
    $fatal(1);
  end

endmodule
